// File: rtl/chord_song_reader_pkg.sv
// rtl/chord_song_reader_pkg.sv - shared ROM word layout, end marker and FSM state encodings
package chord_song_reader_pkg;

    localparam int NOTE_WIDTH     = 6;
    localparam int DURATION_WIDTH = 6;
    localparam int META_WIDTH     = 3;

    // ROM word: [15] advance, [14:12] meta, [11:6] note, [5:0] duration
    localparam int ADV_BIT  = 15;
    localparam int META_LSB = 12;
    localparam int NOTE_LSB = 6;
    localparam int DUR_LSB  = 0;

    localparam logic [META_WIDTH-1:0] END_META = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_ISSUE   = 3'd3,
        S_ADVANCE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    function automatic logic is_end_marker(input logic [15:0] word);
        return !word[ADV_BIT] && (word[META_LSB +: META_WIDTH] == END_META);
    endfunction

endpackage

// File: rtl/chord_song_reader_beat_countdown.sv
// rtl/chord_song_reader_beat_countdown.sv - loadable beat down counter with zero flag
module beat_countdown #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    // load wins over a tick; the count saturates at zero instead of wrapping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/chord_song_reader.sv
// rtl/chord_song_reader.sv - song ROM walker issuing note events; LOOP_SONG_EN selects looping playback
module chord_song_reader
    import chord_song_reader_pkg::*;
#(
    parameter int SONG_BITS = 2,
    parameter int WORD_BITS = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          play,
    input  logic [SONG_BITS-1:0]          song,
    input  logic                          beat,
    input  logic                          slot_free,
    output logic [SONG_BITS+WORD_BITS-1:0] rom_addr,
    input  logic [15:0]                   rom_data,
    output logic                          new_note,
    output logic [NOTE_WIDTH-1:0]         note_to_load,
    output logic [DURATION_WIDTH-1:0]     duration_to_load,
    output logic [META_WIDTH-1:0]         metaData,
    output logic                          song_done
);

    state_t                    state, state_next;
    logic [WORD_BITS-1:0]      word_ptr, ptr_next;
    logic [SONG_BITS-1:0]      song_latched, song_next;
    logic [NOTE_WIDTH-1:0]     pend_note;
    logic [DURATION_WIDTH-1:0] pend_dur;
    logic [META_WIDTH-1:0]     pend_meta;
    logic                      decode_note, issue, cnt_load, step;
    logic [DURATION_WIDTH-1:0] cnt;
    logic                      cnt_zero;

    logic                      rom_adv, rom_end;
    logic [META_WIDTH-1:0]     rom_meta;
    logic [NOTE_WIDTH-1:0]     rom_note;
    logic [DURATION_WIDTH-1:0] rom_dur;

`ifdef LOOP_SONG_EN
    logic loop_hit, loop_pulse;
`endif

    assign rom_adv  = rom_data[ADV_BIT];
    assign rom_meta = rom_data[META_LSB +: META_WIDTH];
    assign rom_note = rom_data[NOTE_LSB +: NOTE_WIDTH];
    assign rom_dur  = rom_data[DUR_LSB +: DURATION_WIDTH];
    assign rom_end  = is_end_marker(rom_data);

    assign rom_addr = {song_latched, word_ptr};

    beat_countdown #(.WIDTH(DURATION_WIDTH)) u_countdown (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (rom_dur),
        .enable     (beat & play),
        .count      (cnt),
        .zero       (cnt_zero)
    );

    // next state / pointer; nothing moves while paused except the IDLE song sample
    always_comb begin
        state_next  = state;
        ptr_next    = word_ptr;
        song_next   = song_latched;
        decode_note = 1'b0;
        issue       = 1'b0;
        cnt_load    = 1'b0;
        step        = 1'b0;
`ifdef LOOP_SONG_EN
        loop_hit    = 1'b0;
`endif
        if (state == S_IDLE) begin
            song_next = song;
        end
        if (play) begin
            case (state)
                S_IDLE:   state_next = S_FETCH;
                S_FETCH:  state_next = S_DECODE;
                S_DECODE: begin
                    if (rom_end) begin
`ifdef LOOP_SONG_EN
                        ptr_next   = '0;
                        state_next = S_FETCH;
                        loop_hit   = 1'b1;
`else
                        state_next = S_DONE;
`endif
                    end else if (rom_adv) begin
                        if (rom_dur == '0) begin
                            step = 1'b1;
                        end else begin
                            cnt_load   = 1'b1;
                            state_next = S_ADVANCE;
                        end
                    end else begin
                        decode_note = 1'b1;
                        state_next  = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (slot_free) begin
                        issue = 1'b1;
                        step  = 1'b1;
                    end
                end
                S_ADVANCE: begin
                    // the zero exit only guards against a counter that was never loaded
                    if (cnt_zero || (beat && (cnt == DURATION_WIDTH'(1)))) begin
                        step = 1'b1;
                    end
                end
                S_DONE: begin
                    if (song != song_latched) begin
                        ptr_next   = '0;
                        state_next = S_IDLE;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
        // moving past the last word of a song counts as reaching its end
        if (step) begin
            if (&word_ptr) begin
`ifdef LOOP_SONG_EN
                ptr_next   = '0;
                state_next = S_FETCH;
                loop_hit   = 1'b1;
`else
                state_next = S_DONE;
`endif
            end else begin
                ptr_next   = word_ptr + 1'b1;
                state_next = S_FETCH;
            end
        end
    end

    // state, pointer, pending note and issued-note output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= S_IDLE;
            word_ptr         <= '0;
            song_latched     <= '0;
            pend_note        <= '0;
            pend_dur         <= '0;
            pend_meta        <= '0;
            new_note         <= 1'b0;
            note_to_load     <= '0;
            duration_to_load <= '0;
            metaData         <= '0;
        end else begin
            state        <= state_next;
            word_ptr     <= ptr_next;
            song_latched <= song_next;
            new_note     <= issue;
            if (decode_note) begin
                pend_note <= rom_note;
                pend_dur  <= rom_dur;
                pend_meta <= rom_meta;
            end
            if (issue) begin
                note_to_load     <= pend_note;
                duration_to_load <= pend_dur;
                metaData         <= pend_meta;
            end
        end
    end

`ifdef LOOP_SONG_EN
    // one-cycle end-of-song pulse each time playback wraps to word 0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            loop_pulse <= 1'b0;
        end else begin
            loop_pulse <= loop_hit;
        end
    end

    assign song_done = loop_pulse;
`else
    assign song_done = (state == S_DONE);
`endif

endmodule

// File: tb/tb_chord_song_reader.sv
// tb/tb_chord_song_reader.sv - scoreboard bench for chord_song_reader
module tb_chord_song_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        play;
    logic [1:0]  song;
    logic        beat;
    logic        slot_free;
    logic [6:0]  rom_addr;
    logic [15:0] rom_data = 16'h0;
    logic        new_note;
    logic [5:0]  note_to_load;
    logic [5:0]  duration_to_load;
    logic [2:0]  metaData;
    logic        song_done;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [15:0] rom [0:127];
    logic [14:0] exp_q[$];
    int          pulse_cyc[$];
    logic [14:0] exp_ev;

    chord_song_reader dut (
        .clk              (clk),
        .reset            (reset),
        .play             (play),
        .song             (song),
        .beat             (beat),
        .slot_free        (slot_free),
        .rom_addr         (rom_addr),
        .rom_data         (rom_data),
        .new_note         (new_note),
        .note_to_load     (note_to_load),
        .duration_to_load (duration_to_load),
        .metaData         (metaData),
        .song_done        (song_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rom_data <= rom[rom_addr];
    end

    function automatic logic [15:0] mk(input logic adv, input logic [2:0] meta,
                                       input logic [5:0] note, input logic [5:0] dur);
        return {adv, meta, note, dur};
    endfunction

    function automatic logic [14:0] ev(input logic [2:0] meta, input logic [5:0] note,
                                       input logic [5:0] dur);
        return {meta, note, dur};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_beat();
        beat = 1'b1;
        @(negedge clk);
        beat = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain(input string name, input int bound);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic push_song0();
        exp_q.push_back(ev(3'd1, 6'd10, 6'd4));
        exp_q.push_back(ev(3'd2, 6'd14, 6'd4));
        exp_q.push_back(ev(3'd3, 6'd17, 6'd4));
    endtask

    // monitor: every new_note pulse is matched against the scoreboard head
    always @(negedge clk) begin
        if (new_note) begin
            pulse_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_note: got %0h expected no pulse",
                         {metaData, note_to_load, duration_to_load});
            end else begin
                exp_ev = exp_q.pop_front();
                check("note_event", {metaData, note_to_load, duration_to_load}, exp_ev);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 128; i++) rom[i] = 16'h7000;
        // song 0
        rom[0] = mk(1'b0, 3'd1, 6'd10, 6'd4);
        rom[1] = mk(1'b0, 3'd2, 6'd14, 6'd4);
        rom[2] = mk(1'b0, 3'd3, 6'd17, 6'd4);
        rom[3] = mk(1'b1, 3'd0, 6'd0, 6'd4);
        rom[4] = 16'h7000;
        // song 1: 32 notes, no end marker
        for (int i = 0; i < 32; i++)
            rom[32 + i] = mk(1'b0, 3'(i % 7), 6'(i), 6'(i + 1));
        // song 2: two notes, a zero-length advance, a 3-beat advance, end
        rom[64] = mk(1'b0, 3'd0, 6'd5, 6'd2);
        rom[65] = mk(1'b0, 3'd4, 6'd6, 6'd3);
        rom[66] = mk(1'b1, 3'd0, 6'd0, 6'd0);
        rom[67] = mk(1'b1, 3'd0, 6'd0, 6'd3);
        rom[68] = 16'h7000;

        reset = 1'b0; play = 1'b0; song = 2'd0; beat = 1'b0; slot_free = 1'b1;
        wait_cycles(3);
        check("rst_new_note", new_note, 0);
        check("rst_note", note_to_load, 0);
        check("rst_duration", duration_to_load, 0);
        check("rst_meta", metaData, 0);
        check("rst_song_done", song_done, 0);
        check("rst_rom_addr", rom_addr, 0);
        reset = 1'b1;
        wait_cycles(2);

`ifdef LOOP_SONG_EN
        push_song0();
        push_song0();
        play = 1'b1;
        drain("loop_first_pass", 60);
        wait_cycles(5);
        repeat (3) send_beat();
        beat = 1'b1;
        @(negedge clk);
        beat = 1'b0;
        wait_cycles(2);
        check("loop_done_pulse", song_done, 1);
        check("loop_addr_wrap", rom_addr, 7'h00);
        wait_cycles(1);
        check("loop_done_clear", song_done, 0);
        drain("loop_reissue", 60);
`else
        // song 0: three chord notes, advance, end
        push_song0();
        pulse_cyc.delete();
        play = 1'b1;
        drain("song0_notes", 60);
        check("song0_pulse_count", pulse_cyc.size(), 3);
        if (pulse_cyc.size() >= 3) begin
            check("song0_gap1", pulse_cyc[1] - pulse_cyc[0], 3);
            check("song0_gap2", pulse_cyc[2] - pulse_cyc[1], 3);
        end
        wait_cycles(5);
        repeat (3) send_beat();
        wait_cycles(3);
        check("song0_done_before_4th_beat", song_done, 0);
        beat = 1'b1;
        @(negedge clk);
        beat = 1'b0;
        wait_cycles(2);
        check("song0_done", song_done, 1);

        // song 1: 32 notes with pointer wrap acting as end
        for (int i = 0; i < 32; i++) exp_q.push_back(ev(3'(i % 7), 6'(i), 6'(i + 1)));
        song = 2'd1;
        drain("song1_notes", 300);
        wait_cycles(1);
        check("song1_done_on_wrap", song_done, 1);

        // song change, then hold in ISSUE with slot_free low
        slot_free = 1'b0;
        exp_q.push_back(ev(3'd0, 6'd5, 6'd2));
        song = 2'd2;
        wait_cycles(1);
        check("song2_done_clear", song_done, 0);
        wait_cycles(1);
        check("song2_addr_start", rom_addr, 7'h40);
        begin
            logic stable = 1'b1;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (new_note || note_to_load != 6'd31 || duration_to_load != 6'd32
                    || metaData != 3'd3) stable = 1'b0;
            end
            check("issue_hold_stable", stable, 1);
        end
        check("issue_hold_addr", rom_addr, 7'h40);
        exp_q.push_back(ev(3'd4, 6'd6, 6'd3));
        slot_free = 1'b1;
        @(negedge clk);
        check("issue_release_pulse", new_note, 1);
        check("issue_release_ptr", rom_addr, 7'h41);
        @(negedge clk);
        check("issue_single_pulse", new_note, 0);
        drain("song2_notes", 30);

        // pause during a 3-beat advance; beats while paused are dropped
        wait_cycles(6);
        play = 1'b0;
        check("pause_addr", rom_addr, 7'h43);
        repeat (5) send_beat();
        check("pause_addr_held", rom_addr, 7'h43);
        check("pause_not_done", song_done, 0);
        play = 1'b1;
        repeat (2) send_beat();
        wait_cycles(5);
        check("resume_two_beats", song_done, 0);
        beat = 1'b1;
        @(negedge clk);
        beat = 1'b0;
        wait_cycles(2);
        check("resume_third_beat_done", song_done, 1);

        // asynchronous reset while waiting in ISSUE on word 1 of song 0
        exp_q.push_back(ev(3'd1, 6'd10, 6'd4));
        song = 2'd0;
        drain("pre_reset_note", 30);
        slot_free = 1'b0;
        wait_cycles(6);
        check("pre_reset_addr", rom_addr, 7'h01);
        check("pre_reset_note_held", note_to_load, 10);
        #2 reset = 1'b0;
        #1;
        check("async_rst_new_note", new_note, 0);
        check("async_rst_note", note_to_load, 0);
        check("async_rst_duration", duration_to_load, 0);
        check("async_rst_meta", metaData, 0);
        check("async_rst_addr", rom_addr, 0);
        @(negedge clk);
        push_song0();
        slot_free = 1'b1;
        reset = 1'b1;
        drain("replay_from_word0", 60);
        wait_cycles(5);
        repeat (4) send_beat();
        wait_cycles(1);
        check("replay_done", song_done, 1);
        wait_cycles(2);
        check("replay_done_level", song_done, 1);
`endif

        wait_cycles(3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/chord_song_reader.md
Name: chord_song_reader

Overview:
- Producer end of the note-load interface feeding the chord generator: walks a song ROM and issues note events (new_note pulse with note, duration and metadata).
- Inserts time advances counted in beats between groups of notes, so chords form from notes issued back-to-back.
- Sits between the song ROM and the chord generator, gated by the top-level play control.

Parameters:
- SONG_BITS, 2, number of selectable songs = 2**SONG_BITS
- WORD_BITS, 5, words per song = 2**WORD_BITS; rom_addr width = SONG_BITS+WORD_BITS

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; all state cleared while 0
- play  in  1  1 = run, 0 = pause (state frozen)
- song  in  SONG_BITS  song select, sampled only in IDLE
- beat  in  1  one-cycle tick, decrements the advance counter
- slot_free  in  1  chord generator can accept a note this cycle
- rom_addr  out  SONG_BITS+WORD_BITS  {song_latched, word_ptr}
- rom_data  in  16  ROM word, valid exactly 1 cycle after rom_addr changes
- new_note  out  1  one-cycle pulse: note_to_load/duration_to_load/metaData valid
- note_to_load  out  6  note code
- duration_to_load  out  6  note duration in beats
- metaData  out  3  note metadata field
- song_done  out  1  level, high from end of song until song change or reset

Behaviour:
- ROM word: [15] advance flag; [14:12] meta; [11:6] note; [5:0] duration. meta==3'b111 with advance=0 is end-of-song marker.
- Reset values: all outputs 0, state IDLE, word_ptr 0, song_latched 0, advance counter 0.
- States: IDLE, FETCH, DECODE, ISSUE, ADVANCE, DONE.
- IDLE: latch song; if play, go FETCH.
- FETCH: rom_addr presented; next cycle DECODE (1-cycle ROM latency).
- DECODE: end marker -> DONE. advance=1 -> load counter with duration; duration==0 -> word_ptr+1, FETCH (no-op); else ADVANCE. advance=0 -> register note/duration/meta, go ISSUE.
- ISSUE: when slot_free: new_note=1 for that cycle, word_ptr+1, go FETCH. Waits indefinitely otherwise; outputs held stable while waiting.
- ADVANCE: each beat decrements counter; on beat with counter==1 -> word_ptr+1, FETCH. Counter never underflows.
- Throughput: back-to-back notes issue at most every 3 cycles (FETCH, DECODE, ISSUE).
- word_ptr wrap: increment from all-ones without end marker -> DONE (treated as end).
- DONE: song_done=1, no new_note. Exits to IDLE (ptr=0, song_done=0) when song input differs from song_latched.
- play=0: every state holds; beats ignored in ADVANCE; no new_note. Resume continues exactly where paused.
- Simultaneous beat and play=0: beat dropped. Simultaneous slot_free and play=0: no issue.
- Reset mid-operation: immediate return to IDLE regardless of state; any in-flight ISSUE is lost.
- note_to_load/duration_to_load/metaData hold last issued value between pulses.

Optional Feature:
- LOOP_SONG_EN defined: end marker or ptr wrap resets word_ptr to 0 and goes FETCH; song_done pulses one cycle per loop instead of latching; DONE state unreachable.
- Undefined: behaviour as above (stop in DONE).

Decomposition:
- Shared package: ROM word field offsets/widths (NOTE_WIDTH 6, DURATION_WIDTH 6, META_WIDTH 3), end-marker meta value 3'b111, state encodings.
- One sub-module: beat_countdown (loadable 6-bit down counter with enable=beat&play, zero flag), reused for note duration logic elsewhere.

Test Plan:
- Song 0 = {note 10 dur 4, note 14 dur 4, note 17 dur 4, advance 4, end}, slot_free=1, play=1 -> three new_note pulses 3 cycles apart with notes 10/14/17, no further pulse until 4th beat, then song_done=1.
- slot_free held 0 for 20 cycles in ISSUE -> new_note stays 0, outputs stable; slot_free=1 -> single pulse next cycle, ptr advances by 1.
- play dropped during ADVANCE with counter 3, 5 beats sent -> counter stays 3; play restored -> exactly 3 more beats to FETCH.
- Reset (0) asserted in ISSUE mid-song -> all outputs 0 same cycle asynchronously, state IDLE; after release, replay starts from word 0.
- Song 1 with no end marker across 32 words of advance=0 notes -> 32 pulses then song_done=1; change song to 2 -> song_done=0, rom_addr={2,0}.
- LOOP_SONG_EN build, song 0 -> after end marker rom_addr returns to {0,0}, song_done one-cycle pulse, note 10 reissued.
